// File: rtl/key_debounce.sv
// key_debounce: per-key 2-flop synchroniser plus debounce FSM producing level and press/release strobes.
// Optional auto-repeat strobes while a key is held are built when KEY_REPEAT_EN is defined.
//
// state | meaning
// IDLE  | key released and stable
// PDEB  | press seen, waiting for it to stay stable
// HELD  | key pressed and stable
// RDEB  | release seen, waiting for it to stay stable
module key_debounce #(
    parameter int N_KEYS        = 4,
    parameter int DEB_CYCLES    = 1_000_000,
    parameter int LONG_CYCLES   = 50_000_000,
    parameter int REPEAT_CYCLES = 10_000_000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [N_KEYS-1:0] key_n,
    output logic [N_KEYS-1:0] key_level,
    output logic [N_KEYS-1:0] key_press,
    output logic [N_KEYS-1:0] key_release,
    output logic [N_KEYS-1:0] key_repeat,
    output logic              key_any
);

    localparam int               CNT_W    = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, PDEB, HELD, RDEB} state_t;

    // Synchroniser resets to "released" so reset exit never looks like a press.
    logic [N_KEYS-1:0] sync1, sync2, pressed;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1 <= '1;
            sync2 <= '1;
        end else begin
            sync1 <= key_n;
            sync2 <= sync1;
        end
    end

    assign pressed = ~sync2;
    assign key_any = |key_press;

`ifdef KEY_REPEAT_EN
    localparam int                HOLD_MAX  = (LONG_CYCLES > REPEAT_CYCLES) ? LONG_CYCLES : REPEAT_CYCLES;
    localparam int                HOLD_W    = (HOLD_MAX > 1) ? $clog2(HOLD_MAX) : 1;
    localparam logic [HOLD_W-1:0] LONG_LOAD = HOLD_W'(LONG_CYCLES - 1);
    localparam logic [HOLD_W-1:0] RPT_LOAD  = HOLD_W'(REPEAT_CYCLES - 1);
`else
    logic unused_cfg;
    assign unused_cfg = (LONG_CYCLES > REPEAT_CYCLES);
`endif

    for (genvar k = 0; k < N_KEYS; k++) begin : g_key
        state_t           state, state_nx;
        logic [CNT_W-1:0] cnt, cnt_nx;
        logic             level, level_nx;
        logic             press, press_nx;
        logic             rel, rel_nx;

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                state <= IDLE;
                cnt   <= '0;
                level <= 1'b0;
                press <= 1'b0;
                rel   <= 1'b0;
            end else begin
                state <= state_nx;
                cnt   <= cnt_nx;
                level <= level_nx;
                press <= press_nx;
                rel   <= rel_nx;
            end
        end

        always_comb begin
            state_nx = state;
            cnt_nx   = cnt;
            level_nx = level;
            press_nx = 1'b0;
            rel_nx   = 1'b0;
            case (state)
                IDLE: begin
                    if (pressed[k]) begin
                        state_nx = PDEB;
                        cnt_nx   = '0;
                    end
                end
                PDEB: begin
                    if (!pressed[k]) begin
                        state_nx = IDLE;
                        cnt_nx   = '0;
                    end else if (cnt == CNT_LAST) begin
                        state_nx = HELD;
                        cnt_nx   = '0;
                        press_nx = 1'b1;
                        level_nx = 1'b1;
                    end else begin
                        cnt_nx = cnt + CNT_W'(1);
                    end
                end
                HELD: begin
                    if (!pressed[k]) begin
                        state_nx = RDEB;
                        cnt_nx   = '0;
                    end
                end
                RDEB: begin
                    if (pressed[k]) begin
                        state_nx = HELD;
                        cnt_nx   = '0;
                    end else if (cnt == CNT_LAST) begin
                        state_nx = IDLE;
                        cnt_nx   = '0;
                        rel_nx   = 1'b1;
                        level_nx = 1'b0;
                    end else begin
                        cnt_nx = cnt + CNT_W'(1);
                    end
                end
                default: begin
                    state_nx = IDLE;
                    cnt_nx   = '0;
                end
            endcase
        end

        assign key_level[k]   = level;
        assign key_press[k]   = press;
        assign key_release[k] = rel;

`ifdef KEY_REPEAT_EN
        // Down-counter reloaded on every (re)entry to HELD; first period is the long one.
        logic [HOLD_W-1:0] hold;
        logic              rpt_phase;
        logic              rpt;

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                hold      <= LONG_LOAD;
                rpt_phase <= 1'b0;
                rpt       <= 1'b0;
            end else begin
                rpt <= 1'b0;
                if (state != HELD || state_nx != HELD) begin
                    hold      <= LONG_LOAD;
                    rpt_phase <= 1'b0;
                end else if (hold == '0) begin
                    rpt       <= 1'b1;
                    rpt_phase <= 1'b1;
                    hold      <= RPT_LOAD;
                end else begin
                    hold <= hold - HOLD_W'(1);
                end
            end
        end

        assign key_repeat[k] = rpt;
`else
        assign key_repeat[k] = 1'b0;
`endif
    end

endmodule

// File: tb/tb_key_debounce.sv
// Self-checking bench for key_debounce: latency, bounce rejection, simultaneous keys, reset, auto-repeat.
module tb_key_debounce;

    localparam int N   = 4;
    localparam int DEB = 8;
    localparam int LNG = 32;
    localparam int RPT = 16;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [N-1:0] key_n = 4'hF;
    logic [N-1:0] key_level, key_press, key_release, key_repeat;
    logic         key_any;

    int checks   = 0;
    int failures = 0;

    key_debounce #(
        .N_KEYS(N), .DEB_CYCLES(DEB), .LONG_CYCLES(LNG), .REPEAT_CYCLES(RPT)
    ) dut (
        .clk(clk), .rst(rst), .key_n(key_n),
        .key_level(key_level), .key_press(key_press), .key_release(key_release),
        .key_repeat(key_repeat), .key_any(key_any)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [N-1:0] keys;
        int           cycles;
        int           presses;
        int           releases;
        int           any_cycles;
        logic [N-1:0] level;
    } vec_t;

    vec_t vecs[13];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Runs n cycles, reporting the first cycle a strobe on channel ch appears, strobe count, level around cycle 11.
    task automatic watch(input int ch, input int n, input bit rel,
                         output int first, output int count, output logic lv10, output logic lv11);
        first = -1;
        count = 0;
        lv10  = 1'bx;
        lv11  = 1'bx;
        for (int i = 1; i <= n; i++) begin
            tick();
            if (rel ? key_release[ch] : key_press[ch]) begin
                count++;
                if (first < 0) first = i;
            end
            if (i == 10) lv10 = key_level[ch];
            if (i == 11) lv11 = key_level[ch];
        end
    endtask

    initial begin
        int   first, count, nz, anycnt, bad, rc, off;
        int   p, r, a;
        int   rpt_at[8];
        logic lv10, lv11;
        logic [N-1:0] val;

        vecs[0]  = '{4'hF, 12, 0, 0, 0, 4'h0};
        vecs[1]  = '{4'hD,  5, 0, 0, 0, 4'h0};
        vecs[2]  = '{4'hF,  1, 0, 0, 0, 4'h0};
        vecs[3]  = '{4'hD,  5, 0, 0, 0, 4'h0};
        vecs[4]  = '{4'hF, 12, 0, 0, 0, 4'h0};
        vecs[5]  = '{4'hD, 20, 1, 0, 1, 4'h2};
        vecs[6]  = '{4'hF,  5, 0, 0, 0, 4'h2};
        vecs[7]  = '{4'hD,  1, 0, 0, 0, 4'h2};
        vecs[8]  = '{4'hF, 15, 0, 1, 0, 4'h0};
        vecs[9]  = '{4'h0, 15, 4, 0, 1, 4'hF};
        vecs[10] = '{4'hF, 15, 0, 4, 0, 4'h0};
        vecs[11] = '{4'h7, 15, 1, 0, 1, 4'h8};
        vecs[12] = '{4'hF, 15, 0, 1, 0, 4'h0};

        // Reset state and quiet period after reset
        #1;
        check("reset_outputs", {key_level, key_press, key_release, key_repeat, 3'b0, key_any}, 32'h0);
        tick(); tick(); tick();
        rst = 1'b0;
        bad = 0;
        for (int i = 0; i < 100; i++) begin
            tick();
            if ({key_level, key_press, key_release, key_repeat, key_any} != '0) bad++;
        end
        check("idle_after_reset", bad, 0);

        // Single press / release latency on key 0
        key_n = 4'hE;
        watch(0, 14, 1'b0, first, count, lv10, lv11);
        check("t2_press_cycle", first, 11);
        check("t2_press_count", count, 1);
        check("t2_level_before", lv10, 1'b0);
        check("t2_level_after", lv11, 1'b1);
        key_n = 4'hF;
        watch(0, 14, 1'b1, first, count, lv10, lv11);
        check("t2_release_cycle", first, 11);
        check("t2_release_count", count, 1);
        check("t2_rel_level_before", lv10, 1'b1);
        check("t2_rel_level_after", lv11, 1'b0);

        // Table of bounce / hold / multi-key vectors
        for (int v = 0; v < 13; v++) begin
            key_n = vecs[v].keys;
            p = 0; r = 0; a = 0;
            for (int c = 0; c < vecs[v].cycles; c++) begin
                tick();
                p += $countones(key_press);
                r += $countones(key_release);
                a += int'(key_any);
            end
            check($sformatf("vec%0d_press", v), p, vecs[v].presses);
            check($sformatf("vec%0d_release", v), r, vecs[v].releases);
            check($sformatf("vec%0d_any", v), a, vecs[v].any_cycles);
            check($sformatf("vec%0d_level", v), key_level, vecs[v].level);
        end

        // Keys 3 and 2 pressed on the same edge
        key_n = 4'h3;
        nz = 0; anycnt = 0; first = -1; val = '0; bad = 0;
        for (int i = 1; i <= 14; i++) begin
            tick();
            anycnt += int'(key_any);
            if (key_press != '0) begin
                nz++;
                val = key_press;
                if (first < 0) first = i;
                if (key_any !== 1'b1) bad++;
            end
        end
        check("t4_press_cycles", nz, 1);
        check("t4_press_value", val, 4'hC);
        check("t4_press_cycle", first, 11);
        check("t4_any_cycles", anycnt, 1);
        check("t4_any_coincident", bad, 0);
        key_n = 4'hF;
        for (int i = 0; i < 15; i++) tick();
        check("t4_released", key_level, 4'h0);

        // Reset during debounce, key held through reset
        key_n = 4'hE;
        bad = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            bad += $countones(key_press) + $countones(key_release);
        end
        check("t5_no_strobe_pre_reset", bad, 0);
        rst = 1'b1;
        #1;
        check("t5_in_reset", {key_level, key_press}, 8'h00);
        tick(); tick();
        rst = 1'b0;
        watch(0, 12, 1'b0, first, count, lv10, lv11);
        check("t5_press_cycle", first, 11);
        check("t5_press_count", count, 1);

        // Hold key 0 for 85 further cycles: auto-repeat offsets relative to the press cycle
        rc = 0; bad = 0;
        for (int i = 0; i < 8; i++) rpt_at[i] = 0;
        for (int j = 2; j <= 86; j++) begin
            tick();
            if (key_repeat[0]) begin
                if (rc < 8) rpt_at[rc] = j;
                rc++;
            end
            if (key_repeat[N-1:1] != '0 || key_press != '0 || key_level != 4'h1) bad++;
        end
        check("t6_other_activity", bad, 0);
`ifdef KEY_REPEAT_EN
        check("t6_repeat_count", rc, 4);
        check("t6_repeat0", rpt_at[0], 32);
        check("t6_repeat1", rpt_at[1], 48);
        check("t6_repeat2", rpt_at[2], 64);
        check("t6_repeat3", rpt_at[3], 80);
`else
        check("t6_repeat_count", rc, 0);
`endif
        key_n = 4'hF;
        r = 0; rc = 0;
        for (int i = 0; i < 15; i++) begin
            tick();
            r += int'(key_release[0]);
            rc += $countones(key_repeat);
        end
        check("t6_release_count", r, 1);
        check("t6_no_repeat_after", rc, 0);
        check("t6_final_level", key_level, 4'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
